// File: rtl/packed_array_reader.sv
`default_nettype none
// ============================================================================
//  Module      : packed_array_reader
//  Description : Snapshots a 4-state packed array from a flat bus and streams
//                it out one innermost element per beat over valid/ready,
//                tagging each beat with its index and an X/Z flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module packed_array_reader #(
    parameter  int D0      = 3,
    parameter  int D1      = 2,
    parameter  int D2      = 3,
    parameter  int ELEM_W  = 3,
    localparam int N       = D0 * D1 * D2,
    localparam int TOTAL_W = N * ELEM_W,
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1,
    localparam int CNT_W   = $clog2(N + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [TOTAL_W-1:0] src,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ELEM_W-1:0]  out_data,
    output logic [IDX_W-1:0]   out_idx,
    output logic               out_unknown,
    output logic               out_last,
    output logic               done,
    output logic [CNT_W-1:0]   unknown_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [TOTAL_W-1:0] shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [ELEM_W-1:0]  data_q,   data_d;
    logic               last_q,   last_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               valid_q,  valid_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;

    logic [ELEM_W-1:0]  shd_elem [N];
    logic [IDX_W-1:0]   idx_inc;
    logic               cur_unknown;

    // Element 0 is the most significant slice of the snapshot.
    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_elem
            assign shd_elem[k] = shadow_q[TOTAL_W-1-k*ELEM_W -: ELEM_W];
        end
    endgenerate

    assign idx_inc     = idx_q + IDX_W'(1);
    // Any X or Z bit in the presented element makes it unknown.
    assign cur_unknown = $isunknown(data_q);

    // Next-state and datapath decisions for the stream controller.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        data_d   = data_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                // X/Z on start must not launch a pass, hence the case-equality.
                if (start === 1'b1) begin
                    shadow_d = src;
                    idx_d    = '0;
                    data_d   = src[TOTAL_W-1 -: ELEM_W];
                    last_d   = (N == 1);
                    cnt_d    = '0;
                    state_d  = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (cur_unknown && (cnt_q != CNT_W'(N))) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (last_q) begin
                        last_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d  = idx_inc;
                        data_d = shd_elem[idx_inc];
                        last_d = (idx_inc == IDX_W'(N - 1));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        valid_d = (state_d == ST_STREAM);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State, snapshot and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy          = busy_q;
    assign out_valid     = valid_q;
    assign out_data      = data_q;
    assign out_idx       = idx_q;
    assign out_unknown   = cur_unknown;
    assign out_last      = last_q;
    assign done          = done_q;
    assign unknown_count = cnt_q;

endmodule
`default_nettype wire
